// File: rtl/snk_clk_pkg.sv
// Shared types and constants for the clock/reset sequencer.
// Sequencer states, divider widths and default qualification lengths.
package snk_clk_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABILIZE,
    HOLD,
    RUN
  } clk_seq_state_t;

  localparam int PIX_DIV_LOG2    = 3;
  localparam int CPU_DIV_LOG2    = 4;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_RST_CYCLES  = 64;

  // Enables and divider only run while the core clock domain is live.
  function automatic logic is_running(
    input clk_seq_state_t s
  );
    return (s == HOLD) || (s == RUN);
  endfunction

endpackage

// File: rtl/snk_clk_reset_seq_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock flag.
// Cleared to 0 so lock is never assumed straight out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snk_clk_reset_seq.sv
// Reset sequencer and pixel/Z80 clock-enable generator after the PLL.
// Optional SNK_CLK_STATUS_EN adds a saturating lock-loss counter output.
module snk_clk_reset_seq
  import snk_clk_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       sys_rst,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic       ce_cpu_n,
  output logic       ready
`ifdef SNK_CLK_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam logic [15:0] LOCK_LIM = 16'(LOCK_CYCLES);
  localparam logic [7:0]  RST_LIM  = 8'(RST_CYCLES);

  clk_seq_state_t state;
  clk_seq_state_t nxt;

  logic                    lock_s;
  logic [15:0]             lock_cnt;
  logic [7:0]              hold_cnt;
  logic [CPU_DIV_LOG2-1:0] div;
  logic                    restart;
  logic                    lost;
  logic                    run_nxt;
  logic                    tick;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state decode; lock loss outranks soft reset and counter expiry.
  always_comb begin
    nxt     = state;
    restart = 1'b0;
    lost    = 1'b0;
    unique case (state)
      RESET: begin
        nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) nxt = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          nxt  = WAIT_LOCK;
          lost = 1'b1;
        end else if (lock_cnt + 16'd1 == LOCK_LIM) begin
          nxt     = HOLD;
          restart = 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          nxt  = WAIT_LOCK;
          lost = 1'b1;
        end else if (soft_reset) begin
          restart = 1'b1;
        end else if (hold_cnt + 8'd1 == RST_LIM) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          nxt  = WAIT_LOCK;
          lost = 1'b1;
        end else if (soft_reset) begin
          nxt     = HOLD;
          restart = 1'b1;
        end
      end
      default: begin
        nxt = RESET;
      end
    endcase
  end

  assign run_nxt = is_running(nxt);
  assign tick    = run_nxt && !restart;

  // State, counters, divider and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET;
      lock_cnt <= '0;
      hold_cnt <= '0;
      div      <= '0;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
      ce_pix   <= 1'b0;
      ce_cpu   <= 1'b0;
      ce_cpu_n <= 1'b0;
    end else begin
      state    <= nxt;
      lock_cnt <= (state == STABILIZE && nxt == STABILIZE)
                  ? lock_cnt + 16'd1 : '0;
      hold_cnt <= (nxt == HOLD && !restart)
                  ? hold_cnt + 8'd1 : '0;
      div      <= tick ? div + 1'b1 : '0;
      sys_rst  <= (nxt != RUN);
      ready    <= (nxt == RUN);
      ce_pix   <= tick && (&div[PIX_DIV_LOG2-1:0]);
      ce_cpu   <= tick && (&div);
      ce_cpu_n <= tick && !div[CPU_DIV_LOG2-1]
                  && (&div[PIX_DIV_LOG2-1:0]);
    end
  end

`ifdef SNK_CLK_STATUS_EN
  // Saturating count of lock losses since power-on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
    end else if (lost && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snk_clk_reset_seq.sv
// Self-checking bench for snk_clk_reset_seq.
// Directed sequence plus randomized lock drops and soft resets.
module tb_snk_clk_reset_seq;

  localparam int LC = 16;
  localparam int RC = 4;

  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_STAB = 2;
  localparam int M_HOLD = 3;
  localparam int M_RUN  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_locked;
  logic soft_reset;
  logic sys_rst;
  logic ce_pix;
  logic ce_cpu;
  logic ce_cpu_n;
  logic ready;
`ifdef SNK_CLK_STATUS_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int m_mode = M_RST;
  bit m_s1   = 1'b0;
  bit m_s2   = 1'b0;
  int m_sc   = 0;
  int m_hc   = 0;
  int m_age  = 0;
  int m_loss = 0;

  snk_clk_reset_seq #(
    .LOCK_CYCLES (LC),
    .RST_CYCLES  (RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .sys_rst    (sys_rst),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu),
    .ce_cpu_n   (ce_cpu_n),
    .ready      (ready)
`ifdef SNK_CLK_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: lock delayed 2 edges, enables from age since HOLD entry.
  task automatic model_edge();
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (m_mode == M_RST) begin
      m_mode = M_WAIT;
    end else if (m_mode >= M_STAB && !ls) begin
      m_mode = M_WAIT;
      if (m_loss < 255) m_loss++;
    end else if (m_mode == M_WAIT) begin
      if (ls) begin
        m_mode = M_STAB;
        m_sc   = 0;
      end
    end else if (m_mode == M_STAB) begin
      m_sc++;
      if (m_sc == LC) begin
        m_mode = M_HOLD;
        m_age  = 0;
        m_hc   = 0;
      end
    end else if (soft_reset) begin
      m_mode = M_HOLD;
      m_age  = 0;
      m_hc   = 0;
    end else begin
      m_age++;
      if (m_mode == M_HOLD) begin
        m_hc++;
        if (m_hc == RC) m_mode = M_RUN;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = M_RST;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_sc   = 0;
    m_hc   = 0;
    m_age  = 0;
    m_loss = 0;
  endtask

  task automatic check_all();
    bit act;
    act = (m_mode >= M_HOLD);
    chk("sys_rst", sys_rst, m_mode != M_RUN);
    chk("ready", ready, m_mode == M_RUN);
    chk("ce_pix", ce_pix, act && m_age > 0 && m_age % 8 == 0);
    chk("ce_cpu", ce_cpu, act && m_age > 0 && m_age % 16 == 0);
    chk("ce_cpu_n", ce_cpu_n, act && m_age % 16 == 8);
`ifdef SNK_CLK_STATUS_EN
    chk_int("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #2;
    check_all();
  endtask

  initial begin
    int e;
    int fall;
    int first_pix;
    int last_cpu;
    int last_pix;
    int cnt;
    int drop_left;
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    soft_reset = 1'b0;
    model_reset();

    repeat (5) tick();
    rst_n = 1'b1;

    e = 0;
    fall = -1;
    first_pix = -1;
    while (e < 60 && (fall < 0 || first_pix < 0)) begin
      tick();
      e++;
      if (fall < 0 && !sys_rst) fall = e;
      if (first_pix < 0 && ce_pix) first_pix = e;
    end
    chk_int("release_edge", fall, 3 + LC + RC);
    chk_int("first_pix_edge", first_pix, 3 + LC + 8);

    last_cpu = -1;
    last_pix = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (ce_pix) begin
        if (last_pix >= 0) chk_int("pix_gap", i - last_pix, 8);
        last_pix = i;
      end
      if (ce_cpu) begin
        chk("cpu_with_pix", ce_pix, 1'b1);
        if (last_cpu >= 0) chk_int("cpu_gap", i - last_cpu, 16);
        last_cpu = i;
      end
      if (ce_cpu_n && last_cpu >= 0)
        chk_int("cpu_n_offset", i - last_cpu, 8);
    end

    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    cnt = sys_rst ? 1 : 0;
    for (int i = 0; i < 20 && sys_rst; i++) begin
      tick();
      if (sys_rst) cnt++;
    end
    chk_int("soft_rst_len", cnt, RC);
    chk("ready_after_soft", ready, 1'b1);

    repeat (10) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    chk("loss_2nd_sys_rst", sys_rst, 1'b0);
    tick();
    chk("loss_3rd_sys_rst", sys_rst, 1'b1);
    chk("loss_3rd_ce_pix", ce_pix, 1'b0);

    pll_locked = 1'b1;
    cnt = 0;
    while (cnt < 40 && !(m_mode == M_STAB && m_sc == 10)) begin
      tick();
      cnt++;
    end
    chk_int("reach_stab_10", m_sc, 10);
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    e = 0;
    fall = -1;
    while (e < 60 && fall < 0) begin
      tick();
      e++;
      if (!sys_rst) fall = e;
    end
    chk_int("relock_release", fall, 3 + LC + RC);

    drop_left = 0;
    for (int i = 0; i < 600; i++) begin
      soft_reset = ($urandom_range(0, 24) == 0);
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 59) == 0)
          drop_left = $urandom_range(1, 4);
      end
      tick();
    end
    soft_reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      repeat (5) tick();
      pll_locked = 1'b0;
      repeat (3) tick();
    end
`ifdef SNK_CLK_STATUS_EN
    chk_int("loss_saturated", int'(lock_loss_cnt), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
